// File: rtl/fifo_word_packer.sv
// Drains narrow elements from an upstream FIFO (registered read data) and packs
// PACK_RATIO of them, little-endian by arrival order, into one word for a downstream FIFO.
module fifo_word_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_empty,
    output logic                           in_rd_en,
    input  logic [IN_WIDTH-1:0]            in_dout,
    input  logic                           out_full,
    output logic                           out_wr_en,
    output logic [IN_WIDTH*PACK_RATIO-1:0] out_din,
    input  logic                           flush,
    output logic                           busy
);

    localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO;
    localparam int CNT_W     = $clog2(PACK_RATIO + 1);
    localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(PACK_RATIO);

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        EMIT
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       issued;
    logic [CNT_W-1:0]       captured;
    logic                   rd_pend;
    logic                   flush_latched;
    logic [OUT_WIDTH-1:0]   lanes;
    logic [OUT_WIDTH-1:0]   merged;
    logic                   word_done;

    // Lane storage with the in-flight element already merged, so a completing
    // capture can be forwarded to out_din on the same edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        merged = lanes;
        if (rd_pend) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (captured == CNT_W'(i)) begin
                    merged[i*IN_WIDTH +: IN_WIDTH] = in_dout;
                end
            end
        end
    end

    assign word_done = rd_pend && (captured + CNT_W'(1) == RATIO_C);

    assign in_rd_en  = reset_n && (state == FILL) && !in_empty
                       && (issued < RATIO_C) && !flush_latched;
    assign out_wr_en = reset_n && (state == EMIT) && !out_full;
    assign busy      = (state != FILL) || (captured != '0) || rd_pend;

    // NOTE: state uses non-blocking assignments; where two assignments to the same
    // register land in one edge, the later one in this block wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: lane storage is reset too, since unfilled lanes of a flushed
            // word must read as zero.
            state         <= FILL;
            issued        <= '0;
            captured      <= '0;
            rd_pend       <= 1'b0;
            flush_latched <= 1'b0;
            lanes         <= '0;
            out_din       <= '0;
        end else begin
            rd_pend <= in_rd_en;
            if (in_rd_en) begin
                issued <= issued + CNT_W'(1);
            end
            if (rd_pend) begin
                lanes    <= merged;
                captured <= captured + CNT_W'(1);
            end

            case (state)
                FILL: begin
                    if (word_done) begin
                        out_din <= merged;
                        state   <= EMIT;
                    end else if (flush && (captured != '0 || rd_pend)) begin
                        flush_latched <= 1'b1;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Only emit once the last accepted read has landed in storage.
                    if (!rd_pend) begin
                        out_din <= lanes;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_wr_en) begin
                        issued        <= '0;
                        captured      <= '0;
                        flush_latched <= 1'b0;
                        lanes         <= '0;
                        state         <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
